// File: rtl/clk_div_scheduler.sv
// Programmable clock-divider controller: divides clk_in by a runtime ratio and runs
// free-running, counted or stoppable bursts. Ratio changes land only on period boundaries.
module clk_div_scheduler #(
  parameter int DIV_W   = 8,
  parameter int CNT_W   = 16,
  parameter int DEF_DIV = 28
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [CNT_W-1:0] cfg_periods,
  input  logic             start,
  input  logic             stop,
  output logic             clk_out,
  output logic             tick,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] period_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [DIV_W-1:0] DEF_DIV_C = DIV_W'(DEF_DIV);

  state_t           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] active_div_q, active_div_d;
  logic [CNT_W-1:0] active_per_q, active_per_d;
  logic [DIV_W-1:0] pend_div_q, pend_div_d;
  logic [CNT_W-1:0] pend_per_q, pend_per_d;
  logic             pend_valid_q, pend_valid_d;
  logic             stop_req_q, stop_req_d;
  logic             clk_out_q, clk_out_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] period_cnt_q, period_cnt_d;

  logic             cfg_fire;
  logic             boundary;
  logic             last_period;
  logic [CNT_W:0]   period_next;

  function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] n);
    return (n < DIV_W'(2)) ? DIV_W'(2) : n;
  endfunction

  function automatic logic [DIV_W-1:0] high_time(input logic [DIV_W-1:0] n);
    return n - (n >> 1);
  endfunction

  assign cfg_ready   = (state_q == S_IDLE) || ((state_q == S_RUN) && !pend_valid_q);
  assign cfg_fire    = cfg_valid && cfg_ready;
  assign busy        = (state_q != S_IDLE);
  assign boundary    = (cnt_q == (active_div_q - DIV_W'(1)));
  assign tick        = busy && boundary;
  assign period_next = {1'b0, period_cnt_q} + (CNT_W+1)'(1);
  assign last_period = (active_per_q != '0) && (period_next == {1'b0, active_per_q});

  assign clk_out    = clk_out_q;
  assign done       = done_q;
  assign period_cnt = period_cnt_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    active_div_d = active_div_q;
    active_per_d = active_per_q;
    pend_div_d   = pend_div_q;
    pend_per_d   = pend_per_q;
    pend_valid_d = pend_valid_q;
    stop_req_d   = stop_req_q;
    clk_out_d    = clk_out_q;
    done_d       = 1'b0;
    period_cnt_d = period_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (cfg_fire) begin
          active_div_d = clamp_div(cfg_div);
          active_per_d = cfg_periods;
        end
        if (start && !stop) begin
          state_d      = S_RUN;
          cnt_d        = '0;
          clk_out_d    = 1'b1;
          period_cnt_d = '0;
          stop_req_d   = 1'b0;
        end
      end
      default: begin
        if ((state_q == S_RUN) && cfg_fire) begin
          pend_valid_d = 1'b1;
          pend_div_d   = clamp_div(cfg_div);
          pend_per_d   = cfg_periods;
        end
        if ((state_q == S_RUN) && stop) begin
          state_d    = S_DRAIN;
          stop_req_d = 1'b1;
        end
        if (boundary) begin
          cnt_d = '0;
          if (!period_next[CNT_W]) period_cnt_d = period_next[CNT_W-1:0];
          if (last_period || stop_req_q) begin
            state_d      = S_IDLE;
            stop_req_d   = 1'b0;
            done_d       = 1'b1;
            clk_out_d    = 1'b0;
            pend_valid_d = 1'b0;
            // A counted run that ends naturally still honours the newest accepted ratio.
            if (!stop_req_q) begin
              if (pend_valid_q) begin
                active_div_d = pend_div_q;
                active_per_d = pend_per_q;
              end else if (cfg_fire) begin
                active_div_d = clamp_div(cfg_div);
                active_per_d = cfg_periods;
              end
            end
          end else begin
            if (pend_valid_q) begin
              active_div_d = pend_div_q;
              active_per_d = pend_per_q;
              pend_valid_d = 1'b0;
            end
            clk_out_d = 1'b1;
          end
        end else begin
          cnt_d     = cnt_q + DIV_W'(1);
          clk_out_d = (cnt_d < high_time(active_div_q));
        end
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      active_div_q <= DEF_DIV_C;
      active_per_q <= '0;
      pend_valid_q <= 1'b0;
      stop_req_q   <= 1'b0;
      clk_out_q    <= 1'b0;
      done_q       <= 1'b0;
      period_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      active_div_q <= active_div_d;
      active_per_q <= active_per_d;
      pend_valid_q <= pend_valid_d;
      stop_req_q   <= stop_req_d;
      clk_out_q    <= clk_out_d;
      done_q       <= done_d;
      period_cnt_q <= period_cnt_d;
    end
  end

  // Pending payload is qualified by pend_valid_q, so it needs no reset.
  always_ff @(posedge clk_in) begin
    pend_div_q <= pend_div_d;
    pend_per_q <= pend_per_d;
  end

endmodule

// File: tb/tb_clk_div_scheduler.sv
// Self-checking bench for clk_div_scheduler: per-cycle expected outputs are queued when a
// run is launched and popped/compared each cycle on the falling edge.
module tb_clk_div_scheduler;

  localparam int BIG = 1 << 30;

  logic        clk_in = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [7:0]  cfg_div = 8'd0;
  logic [15:0] cfg_periods = 16'd0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        clk_out;
  logic        tick;
  logic        busy;
  logic        done;
  logic [15:0] period_cnt;

  clk_div_scheduler #(.DIV_W(8), .CNT_W(16), .DEF_DIV(28)) dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_div     (cfg_div),
    .cfg_periods (cfg_periods),
    .start       (start),
    .stop        (stop),
    .clk_out     (clk_out),
    .tick        (tick),
    .busy        (busy),
    .done        (done),
    .period_cnt  (period_cnt)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic        clk;
    logic        tck;
    logic        bsy;
    logic        dne;
    logic        rdy;
    logic [15:0] pcnt;
  } exp_t;

  typedef struct {
    int div;
    int periods;
    int stopk;
    int h;
    int l;
    int endk;
    int pcnt;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[8];
  int   errors = 0;
  int   checks = 0;

  function automatic exp_t mk(input logic c, input logic t, input logic b, input logic d,
                              input logic r, input int p);
    exp_t e;
    e.clk  = c;
    e.tck  = t;
    e.bsy  = b;
    e.dne  = d;
    e.rdy  = r;
    e.pcnt = 16'(p);
    return e;
  endfunction

  function automatic exp_t run_rec(input int n, input int h, input int k, input int endk,
                                   input int stopk, input int pend);
    int ph;
    if (k < endk) begin
      ph = k % n;
      return mk(ph < h, ph == n - 1, 1'b1, 1'b0, !(stopk >= 0 && k > stopk), k / n);
    end else if (k == endk) begin
      return mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, pend);
    end
    return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, pend);
  endfunction

  task automatic check_next(input string name, input int k);
    exp_t e;
    exp_t a;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s k=%0d scoreboard empty", name, k);
      return;
    end
    e = exp_q.pop_front();
    a.clk  = clk_out;
    a.tck  = tick;
    a.bsy  = busy;
    a.dne  = done;
    a.rdy  = cfg_ready;
    a.pcnt = period_cnt;
    if (a !== e) begin
      errors++;
      $display("FAIL %s k=%0d got clk=%b tick=%b busy=%b done=%b rdy=%b pcnt=%0d expected clk=%b tick=%b busy=%b done=%b rdy=%b pcnt=%0d",
               name, k, a.clk, a.tck, a.bsy, a.dne, a.rdy, a.pcnt,
               e.clk, e.tck, e.bsy, e.dne, e.rdy, e.pcnt);
    end
  endtask

  task automatic reset_check(input string name);
    rst       = 1'b1;
    start     = 1'b0;
    stop      = 1'b0;
    cfg_valid = 1'b0;
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0));
    @(negedge clk_in);
    check_next(name, 0);
    rst = 1'b0;
  endtask

  task automatic do_run(input string name, input int n, input int h, input int endk,
                        input int stopk, input int pend, input int ncyc);
    for (int k = 0; k < ncyc; k++) exp_q.push_back(run_rec(n, h, k, endk, stopk, pend));
    start = 1'b1;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk_in);
      check_next(name, k);
      start = 1'b0;
      stop  = (k == stopk);
    end
    stop = 1'b0;
  endtask

  initial begin
    vecs[0] = '{5,   3, -1,   3,   2,  15, 3};
    vecs[1] = '{6,   0,  1,   3,   3,   6, 1};
    vecs[2] = '{1,   2, -1,   1,   1,   4, 2};
    vecs[3] = '{0,   3, -1,   1,   1,   6, 3};
    vecs[4] = '{7,   0,  6,   4,   3,  14, 2};
    vecs[5] = '{4,   2,  7,   2,   2,   8, 2};
    vecs[6] = '{9,   1,  3,   5,   4,   9, 1};
    vecs[7] = '{255, 1, -1, 128, 127, 255, 1};

    reset_check("reset_state");
    do_run("default_div28", 28, 14, BIG, -1, 0, 40);
    reset_check("rst_mid_period");

    // Ratio change mid-period with a second offer held off until the boundary.
    for (int k = 0; k < 34; k++) begin
      logic r;
      r = (k <= 7) || (k == 28);
      if (k < 28) exp_q.push_back(mk(k < 14, k == 27, 1'b1, 1'b0, r, 0));
      else        exp_q.push_back(mk((k - 28) < 5, (k - 28) == 9, 1'b1, 1'b0, r, 1));
    end
    start = 1'b1;
    for (int k = 0; k < 34; k++) begin
      @(negedge clk_in);
      check_next("ratio_change", k);
      start = 1'b0;
      if (k == 7) begin
        cfg_valid   = 1'b1;
        cfg_div     = 8'd10;
        cfg_periods = 16'd0;
      end else if (k == 8) begin
        cfg_div = 8'd4;
      end else if (k == 29) begin
        cfg_valid = 1'b0;
      end
    end
    reset_check("rst_with_pending");
    do_run("after_rst_div28", 28, 14, BIG, -1, 0, 60);
    reset_check("reset_again");

    for (int i = 0; i < 8; i++) begin
      cfg_valid   = 1'b1;
      cfg_div     = 8'(vecs[i].div);
      cfg_periods = 16'(vecs[i].periods);
      @(negedge clk_in);
      cfg_valid = 1'b0;
      do_run($sformatf("vec%0d", i), vecs[i].h + vecs[i].l, vecs[i].h, vecs[i].endk,
             vecs[i].stopk, vecs[i].pcnt, vecs[i].endk + 2);
    end

    // start and stop together in IDLE: no run, period_cnt holds.
    for (int k = 0; k < 4; k++) exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, vecs[7].pcnt));
    start = 1'b1;
    stop  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_in);
      check_next("start_stop_idle", k);
      start = 1'b0;
      stop  = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
